// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared state encoding and default width for the serial adder
package add_pkg;

  localparam int ADD_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } add_state_t;

endpackage

// File: rtl/ha_cell.sv
// rtl/ha_cell.sv - one-bit half adder cell
module ha_cell (
  input  logic i_a,
  input  logic i_b,
  output logic sum,
  output logic carry
);

  assign sum   = i_a ^ i_b;
  assign carry = i_a & i_b;

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder, LSB first, one bit pair per clock
module serial_add_ctrl
  import add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  add_state_t       state;
  add_state_t       state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry_q;
  logic [CNT_W-1:0] bit_cnt;

  logic             start_ok;
  logic             shift_en;
  logic             ha0_sum;
  logic             ha0_carry;
  logic             sum_bit;
  logic             ha1_carry;
  logic             carry_nxt;

  // Full-adder slice: two half adders chained, carries merged by OR.
  ha_cell u_ha0 (
    .i_a   (a_sh[0]),
    .i_b   (b_sh[0]),
    .sum   (ha0_sum),
    .carry (ha0_carry)
  );

  ha_cell u_ha1 (
    .i_a   (ha0_sum),
    .i_b   (carry_q),
    .sum   (sum_bit),
    .carry (ha1_carry)
  );

  assign carry_nxt = ha0_carry | ha1_carry;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    start_ok  = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          start_ok  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        o_busy   = 1'b1;
        shift_en = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Sum bits enter at the MSB so the word is aligned after WIDTH shifts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      bit_cnt <= '0;
    end else if (start_ok) begin
      a_sh    <= i_a;
      b_sh    <= i_b;
      sum_sh  <= '0;
      carry_q <= i_cin;
      bit_cnt <= '0;
    end else if (shift_en) begin
      a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
      sum_sh  <= {sum_bit, sum_sh[WIDTH-1:1]};
      carry_q <= carry_nxt;
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  assign o_sum   = sum_sh;
  assign o_carry = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
    .o_carry (carry)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int unsigned s;
    s = int'(x) + int'(y) + int'(c);
    return s[W:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_pulses++;
    check("busy_done_exclusive", 64'(busy & done), 64'd0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input int pulse_at);
    int n;
    int d0;
    logic [W:0] e;
    e = ref_add(ta, tb_, tc);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    tick();
    start = 1'b0;
    d0 = done_pulses;
    check("busy_after_start", 64'(busy), 64'd1);
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    n = 0;
    while (busy && n < 40) begin
      if (n + 1 == pulse_at) begin
        start = 1'b1; a = 8'h11; b = 8'h22;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check("busy_cycles", 64'(n), 64'(W));
    check("done_pulse", 64'(done), 64'd1);
    check("sum", 64'(sum), 64'(e[W-1:0]));
    check("carry", 64'(carry), 64'(e[W]));
    tick();
    check("done_one_cycle", 64'(done), 64'd0);
    repeat (12) tick();
    check("sum_hold", 64'(sum), 64'(e[W-1:0]));
    check("carry_hold", 64'(carry), 64'(e[W]));
    check("done_count", 64'(done_pulses - d0), 64'd1);
  endtask

  initial begin
    int n;
    int d0;
    int last_done_cyc;
    logic [W:0] ex;
    logic [W:0] next_ex;

    repeat (2) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_carry", 64'(carry), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op(8'h00, 8'h00, 1'b0, -1);
    run_op(8'hFF, 8'h01, 1'b0, -1);
    run_op(8'hA5, 8'h5A, 1'b1, -1);
    run_op(8'hA5, 8'h5A, 1'b0, -1);
    run_op(8'h3C, 8'h4B, 1'b1, 3);

    // abort mid-operation
    a = 8'h55; b = 8'h0F; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    d0 = done_pulses;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_carry", 64'(carry), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check("abort_no_done", 64'(done_pulses - d0), 64'd0);
    run_op(8'h7F, 8'h01, 1'b0, -1);

    // back-to-back random operations with start held high
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    ex = ref_add(a, b, cin);
    start = 1'b1;
    d0 = done_pulses;
    last_done_cyc = 0;
    tick();
    for (int i = 0; i < 200; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      next_ex = ref_add(a, b, cin);
      n = 0;
      while (!done && n < 40) begin
        tick();
        n++;
      end
      check("b2b_latency", 64'(n), 64'(W));
      check("b2b_sum", 64'(sum), 64'(ex[W-1:0]));
      check("b2b_carry", 64'(carry), 64'(ex[W]));
      if (i > 0) check("b2b_period", 64'(cyc - last_done_cyc), 64'(W + 2));
      last_done_cyc = cyc;
      tick();
      if (i == 199) start = 1'b0;
      tick();
      ex = next_ex;
    end
    start = 1'b0;
    repeat (12) tick();
    check("b2b_done_count", 64'(done_pulses - d0), 64'd200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
